// File: rtl/counter_seq_ctrl_if.sv
// Request/grant and counter-control bundle between two requesters, the sequencer and a shared 3-bit step counter.
// Latency: none, this is wiring only.
// Backpressure: requesters hold req high until they see their gnt.
interface counter_seq_ctrl_if #(
  parameter int STEP_W = 8
);
  logic              req0;
  logic              mode0;
  logic [STEP_W-1:0] len0;
  logic              req1;
  logic              mode1;
  logic [STEP_W-1:0] len1;
  logic [2:0]        count_in;
  logic              gnt0;
  logic              gnt1;
  logic              cnt_clear;
  logic              cnt_en;
  logic              cnt_mode;
  logic              busy;
  logic              done;
  logic              done_id;
  logic              err;

  // Sequencer side: it receives the requests and the counter code, and drives the grants and counter controls.
  modport master (
    input  req0, mode0, len0, req1, mode1, len1, count_in,
    output gnt0, gnt1, cnt_clear, cnt_en, cnt_mode, busy, done, done_id, err
  );

  // Environment side: the requesters and the counter.
  modport slave (
    output req0, mode0, len0, req1, mode1, len1, count_in,
    input  gnt0, gnt1, cnt_clear, cnt_en, cnt_mode, busy, done, done_id, err
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Round-robin sequencer that shares one binary/Gray step counter between two requesters and checks the returned code.
// Latency: request sampled at edge k; gnt and cnt_clear are high from k+1, cnt_en is high from k+2 for len cycles, then a 1-cycle done pulse.
// Backpressure: requests are held until granted; requests are ignored outside IDLE, and a mismatch only sets the sticky err flag.
module counter_seq_ctrl #(
  parameter int STEP_W = 8
) (
  input logic               clk,
  input logic               reset,
  counter_seq_ctrl_if.master io
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_ptr, w_ptr_nxt;          // 1 = requester 1 wins a tie
  logic              r_id, w_id_nxt;            // index of the granted requester
  logic              r_mode, w_mode_nxt;
  logic [STEP_W-1:0] r_len, w_len_nxt;
  logic [STEP_W-1:0] r_remaining, w_remaining_nxt;
  logic [2:0]        r_idx, w_idx_nxt;          // model step index; the code is derived from it
  logic [2:0]        w_expected;
  logic              r_err, w_err_nxt;

  logic r_gnt0, r_gnt1, r_clear, r_en, r_cnt_mode, r_busy, r_done, r_done_id;
  logic w_gnt0_nxt, w_gnt1_nxt, w_clear_nxt, w_en_nxt, w_cnt_mode_nxt;
  logic w_busy_nxt, w_done_nxt, w_done_id_nxt;

  // The expected code is the step index, Gray-encoded when the run uses Gray mode.
  assign w_expected = r_mode ? (r_idx ^ (r_idx >> 1)) : r_idx;

  // Next state, arbitration and bookkeeping. Outputs are decoded from the next state so they can be registered.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_id_nxt        = r_id;
    w_mode_nxt      = r_mode;
    w_len_nxt       = r_len;
    w_remaining_nxt = r_remaining;
    w_idx_nxt       = r_idx;
    w_err_nxt       = r_err;

    case (r_state)
      S_IDLE: begin
        if (io.req0 && (!io.req1 || !r_ptr)) begin
          w_id_nxt    = 1'b0;
          w_mode_nxt  = io.mode0;
          w_len_nxt   = io.len0;
          w_ptr_nxt   = 1'b1;
          w_state_nxt = S_CLEAR;
        end else if (io.req1) begin
          w_id_nxt    = 1'b1;
          w_mode_nxt  = io.mode1;
          w_len_nxt   = io.len1;
          w_ptr_nxt   = 1'b0;
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_remaining_nxt = r_len;
        w_idx_nxt       = 3'd0;
        w_state_nxt     = (r_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        w_remaining_nxt = r_remaining - STEP_W'(1);
        w_idx_nxt       = r_idx + 3'd1;
        if (r_remaining == STEP_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // The counter is compared whenever it should be holding a known step value.
    if ((r_state == S_RUN || r_state == S_DONE) && io.count_in != w_expected) begin
      w_err_nxt = 1'b1;
    end

    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_gnt0_nxt     = (w_state_nxt == S_CLEAR || w_state_nxt == S_RUN) && !w_id_nxt;
    w_gnt1_nxt     = (w_state_nxt == S_CLEAR || w_state_nxt == S_RUN) && w_id_nxt;
    w_clear_nxt    = (w_state_nxt == S_CLEAR);
    w_en_nxt       = (w_state_nxt == S_RUN);
    w_cnt_mode_nxt = w_busy_nxt && w_mode_nxt;
    w_done_nxt     = (w_state_nxt == S_DONE);
    w_done_id_nxt  = w_done_nxt && w_id_nxt;
  end

  // State, latched request fields and registered outputs; reset overrides everything, including mid-run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_id        <= 1'b0;
      r_mode      <= 1'b0;
      r_len       <= '0;
      r_remaining <= '0;
      r_idx       <= 3'd0;
      r_err       <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_clear     <= 1'b0;
      r_en        <= 1'b0;
      r_cnt_mode  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_done_id   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_id        <= w_id_nxt;
      r_mode      <= w_mode_nxt;
      r_len       <= w_len_nxt;
      r_remaining <= w_remaining_nxt;
      r_idx       <= w_idx_nxt;
      r_err       <= w_err_nxt;
      r_gnt0      <= w_gnt0_nxt;
      r_gnt1      <= w_gnt1_nxt;
      r_clear     <= w_clear_nxt;
      r_en        <= w_en_nxt;
      r_cnt_mode  <= w_cnt_mode_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_done_id   <= w_done_id_nxt;
    end
  end

  assign io.gnt0      = r_gnt0;
  assign io.gnt1      = r_gnt1;
  assign io.cnt_clear = r_clear;
  assign io.cnt_en    = r_en;
  assign io.cnt_mode  = r_cnt_mode;
  assign io.busy      = r_busy;
  assign io.done      = r_done;
  assign io.done_id   = r_done_id;
  assign io.err       = r_err;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: a run-level reference model plus an emulated shared counter driven by the DUT.
// Latency: every cycle the DUT outputs are compared at the falling edge against the model's planned cycle.
// Backpressure: requesters are driven from directed scenarios, then from random traffic with occasional resets and code faults.
module tb_counter_seq_ctrl;
  localparam int STEP_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  counter_seq_ctrl_if #(.STEP_W(STEP_W)) bus ();

  counter_seq_ctrl #(.STEP_W(STEP_W)) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  // One planned cycle of expected outputs.
  typedef struct packed {
    logic       gnt0;
    logic       gnt1;
    logic       clr;
    logic       en;
    logic       mode;
    logic       busy;
    logic       done;
    logic       done_id;
    logic       chk;
    logic [2:0] code_exp;
    logic [7:0] run_idx;
  } cyc_t;

  cyc_t plan[$];
  cyc_t cur = '0;
  bit   ptr_m = 1'b0;
  bit   err_m = 1'b0;
  bit   inject_arm = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  logic [2:0] bin_seq [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [2:0] gray_seq[8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  // Emulated shared counter.
  logic [2:0] ctr_idx = 3'd0;
  logic       ctr_mode = 1'b0;

  // Snapshot of the most recently simulated cycle.
  logic       s_gnt0, s_gnt1, s_clr, s_en, s_mode, s_busy, s_done, s_done_id, s_err;
  logic [2:0] s_code;

  function automatic logic [2:0] seq_code(bit m, int n);
    int k;
    k = n % 8;
    return m ? gray_seq[k] : bin_seq[k];
  endfunction

  task automatic chk_b(string name, logic act, logic expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %b want %b", name, cyc, act, expv);
    end
  endtask

  task automatic chk_i(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d want %0d", name, cyc, act, expv);
    end
  endtask

  task automatic build_run(bit id, bit m, int len);
    cyc_t c;
    c = '0; c.gnt0 = !id; c.gnt1 = id; c.clr = 1'b1; c.mode = m; c.busy = 1'b1;
    plan.push_back(c);
    for (int i = 0; i < len; i++) begin
      c = '0; c.gnt0 = !id; c.gnt1 = id; c.en = 1'b1; c.mode = m; c.busy = 1'b1;
      c.chk = 1'b1; c.code_exp = seq_code(m, i); c.run_idx = 8'(i);
      plan.push_back(c);
    end
    c = '0; c.busy = 1'b1; c.done = 1'b1; c.done_id = id; c.chk = 1'b1; c.code_exp = seq_code(m, len);
    plan.push_back(c);
  endtask

  // Advance the reference model across one rising edge using the inputs stable at that edge.
  task automatic model_update(bit inj_now);
    bit g;
    bit id;
    if (!reset) begin
      plan.delete();
      cur = '0;
      ptr_m = 1'b0;
      err_m = 1'b0;
      return;
    end
    if (inj_now) err_m = 1'b1;
    g = 1'b0;
    id = 1'b0;
    if (!cur.busy && plan.size() == 0) begin
      if (bus.req0 && bus.req1) begin g = 1'b1; id = ptr_m; end
      else if (bus.req0)        begin g = 1'b1; id = 1'b0;  end
      else if (bus.req1)        begin g = 1'b1; id = 1'b1;  end
      if (g) begin
        build_run(id, id ? bus.mode1 : bus.mode0, id ? int'(bus.len1) : int'(bus.len0));
        ptr_m = !id;
      end
    end
    if (plan.size() != 0) cur = plan.pop_front();
    else cur = '0;
  endtask

  // One clock cycle: drive count_in, compare outputs, cross the edge, update counter and model.
  task automatic step();
    logic [2:0] code;
    bit inj_now;
    code = ctr_mode ? gray_seq[ctr_idx] : bin_seq[ctr_idx];
    inj_now = inject_arm && cur.en && (cur.run_idx == 8'd1);
    if (inj_now) begin
      code = 3'b010;
      inject_arm = 1'b0;
    end
    bus.count_in = code;
    #1;
    chk_b("gnt0", bus.gnt0, cur.gnt0);
    chk_b("gnt1", bus.gnt1, cur.gnt1);
    chk_b("cnt_clear", bus.cnt_clear, cur.clr);
    chk_b("cnt_en", bus.cnt_en, cur.en);
    chk_b("busy", bus.busy, cur.busy);
    chk_b("done", bus.done, cur.done);
    chk_b("err", bus.err, err_m);
    if (cur.clr || cur.en) chk_b("cnt_mode", bus.cnt_mode, cur.mode);
    if (cur.done) chk_b("done_id", bus.done_id, cur.done_id);
    if (cur.chk && !inj_now) chk_i("count_in", 32'(code), 32'(cur.code_exp));
    s_gnt0 = bus.gnt0; s_gnt1 = bus.gnt1; s_clr = bus.cnt_clear; s_en = bus.cnt_en;
    s_mode = bus.cnt_mode; s_busy = bus.busy; s_done = bus.done; s_done_id = bus.done_id;
    s_err = bus.err; s_code = code;
    @(posedge clk);
    if (s_clr) begin
      ctr_idx = 3'd0;
      ctr_mode = s_mode;
    end else if (s_en) begin
      ctr_idx = ctr_idx + 3'd1;
    end
    model_update(inj_now);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until_done(input int max, output int en_cnt, output int clr_cnt);
    bit ok;
    en_cnt = 0;
    clr_cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      if (s_en) en_cnt++;
      if (s_clr) clr_cnt++;
      if (s_done) ok = 1'b1;
    end
    chk_b("run_reached_done", ok, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle %0d: got timeout want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt;
    int clr_cnt;
    bus.req0 = 1'b1; bus.mode0 = 1'b0; bus.len0 = 8'd5;
    bus.req1 = 1'b0; bus.mode1 = 1'b0; bus.len1 = 8'd0;
    bus.count_in = 3'd0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset held with req0 high: everything quiet.
    repeat (3) step();
    chk_i("reset_outputs", 32'({s_gnt0, s_gnt1, s_clr, s_en, s_mode, s_busy, s_done, s_done_id, s_err}), 32'd0);

    // Release: grant + clear next cycle, enable one cycle later; binary run of 5.
    reset = 1'b1;
    step();
    step();
    chk_b("first_gnt0", s_gnt0, 1'b1);
    chk_b("first_clear", s_clr, 1'b1);
    chk_b("first_clear_no_en", s_en, 1'b0);
    bus.req0 = 1'b0;
    step();
    chk_b("first_en", s_en, 1'b1);
    run_until_done(20, en_cnt, clr_cnt);
    chk_i("bin5_en_cycles", 32'(en_cnt + 1), 32'd5);
    chk_i("bin5_final_code", 32'(s_code), 32'd5);
    chk_b("bin5_done_id", s_done_id, 1'b0);
    chk_b("bin5_err", s_err, 1'b0);

    // Gray run of 10 on requester 1 wraps past 8 steps.
    bus.req1 = 1'b1; bus.mode1 = 1'b1; bus.len1 = 8'd10;
    step();
    bus.req1 = 1'b0;
    run_until_done(40, en_cnt, clr_cnt);
    chk_i("gray10_en_cycles", 32'(en_cnt), 32'd10);
    chk_i("gray10_final_code", 32'(s_code), 32'd3);
    chk_b("gray10_done_id", s_done_id, 1'b1);
    chk_b("gray10_err", s_err, 1'b0);

    // Zero-length run: clear then done, never enabled.
    bus.req0 = 1'b1; bus.len0 = 8'd0;
    step();
    bus.req0 = 1'b0;
    run_until_done(10, en_cnt, clr_cnt);
    chk_i("len0_en_cycles", 32'(en_cnt), 32'd0);
    chk_i("len0_final_code", 32'(s_code), 32'd0);

    // Both requesting from reset: grants alternate 0,1,0,1, each run with its own clear.
    reset = 1'b0;
    bus.req0 = 1'b1; bus.mode0 = 1'b1; bus.len0 = 8'd3;
    bus.req1 = 1'b1; bus.mode1 = 1'b0; bus.len1 = 8'd2;
    repeat (2) step();
    reset = 1'b1;
    for (int r = 0; r < 4; r++) begin
      run_until_done(20, en_cnt, clr_cnt);
      chk_b("alt_done_id", s_done_id, (r % 2) == 1);
      chk_i("alt_clear_count", 32'(clr_cnt), 32'd1);
      chk_i("alt_en_cycles", 32'(en_cnt), (r % 2) == 1 ? 32'd2 : 32'd3);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) step();

    // Corrupted code on the second binary RUN cycle: sticky err.
    bus.req0 = 1'b1; bus.mode0 = 1'b0; bus.len0 = 8'd6;
    inject_arm = 1'b1;
    step();
    bus.req0 = 1'b0;
    run_until_done(20, en_cnt, clr_cnt);
    chk_b("fault_err_at_done", s_err, 1'b1);
    repeat (3) step();
    chk_b("fault_err_sticky", s_err, 1'b1);

    // Reset in the middle of a run drops everything at the next edge.
    bus.req0 = 1'b1; bus.len0 = 8'd20;
    step();
    bus.req0 = 1'b0;
    repeat (4) step();
    chk_b("midrun_en_before", s_en, 1'b1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk_b("midrun_gnt0", s_gnt0, 1'b0);
    chk_b("midrun_en", s_en, 1'b0);
    chk_b("midrun_busy", s_busy, 1'b0);
    chk_b("midrun_err_cleared", s_err, 1'b0);

    // Random traffic, including len/mode changes while granted, rare resets and faults.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 249) != 0);
      bus.req0  = ($urandom_range(0, 2) == 0);
      bus.req1  = ($urandom_range(0, 2) == 0);
      bus.mode0 = 1'($urandom_range(0, 1));
      bus.mode1 = 1'($urandom_range(0, 1));
      bus.len0  = 8'($urandom_range(0, 12));
      bus.len1  = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 39) == 0) inject_arm = 1'b1;
      step();
    end
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (30) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
